// File: rtl/lse_acc_ctrl_pkg.sv
// Shared constants, state type and identity helper for the log-sum-exp accumulation controller.
package lse_acc_ctrl_pkg;

    localparam int LUT_SIZE      = 16;
    localparam int LUT_PRECISION = 8;
    localparam int LUT_ADDR_W    = $clog2(LUT_SIZE);

    localparam logic [23:0] NEG_INF_24       = 24'h800000;
    localparam logic [5:0]  NEG_INF_6_LANE   = {1'b0, 5'd16};
    localparam logic [23:0] NEG_INF_6_PACKED = {4{NEG_INF_6_LANE}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC_ISSUE,
        ST_ACC_WB,
        ST_DONE
    } lse_acc_state_t;

    // Additive identity of the log domain for the selected lane format.
    function automatic logic [23:0] acc_identity(input logic [1:0] mode);
        return (mode == 2'd0) ? NEG_INF_24 : NEG_INF_6_PACKED;
    endfunction

endpackage

// File: rtl/lse_acc_ctrl_lut.sv
// Register-file correction LUT: one write port, whole table visible as a static output.
module lse_lut_regs
    import lse_acc_ctrl_pkg::*;
(
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_we,
    input  logic [LUT_ADDR_W-1:0]                    i_addr,
    input  logic [LUT_PRECISION-1:0]                 i_wdata,
    output logic [LUT_SIZE-1:0][LUT_PRECISION-1:0]   o_table
);

    logic [LUT_PRECISION-1:0] lut_reg [LUT_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_SIZE; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    lut_reg[gi] <= '0;
                end else if (i_we && (i_addr == LUT_ADDR_W'(gi))) begin
                    lut_reg[gi] <= i_wdata;
                end
            end
            assign o_table[gi] = lut_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/lse_acc_ctrl.sv
// Folds a stream of log-domain operands into one log-sum-exp result through an external lse_add.
// Define LSE_ACC_PIPE_EN to register the stream operand before lse_add (two cycles per element).
module lse_acc_ctrl
    import lse_acc_ctrl_pkg::*;
#(
    parameter int p_data_width = 24,
    parameter int p_len_width  = 16
)
(
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_start,
    input  logic [p_len_width-1:0]                   i_len,
    input  logic [1:0]                               i_pe_mode,
    input  logic                                     i_data_valid,
    output logic                                     o_data_ready,
    input  logic [p_data_width-1:0]                  i_data,
    output logic [p_data_width-1:0]                  o_lse_a,
    output logic [p_data_width-1:0]                  o_lse_b,
    output logic [1:0]                               o_lse_mode,
    input  logic [p_data_width-1:0]                  i_lse_sum,
    input  logic                                     i_lut_we,
    input  logic [LUT_ADDR_W-1:0]                    i_lut_addr,
    input  logic [LUT_PRECISION-1:0]                 i_lut_wdata,
    output logic [LUT_SIZE-1:0][LUT_PRECISION-1:0]   o_lut_table,
    output logic                                     o_result_valid,
    input  logic                                     i_result_ready,
    output logic [p_data_width-1:0]                  o_result,
    output logic                                     o_busy
);

    localparam logic [p_len_width-1:0] LEN_ONE = 1;

    lse_acc_state_t            state_reg;
    logic [p_data_width-1:0]   acc_reg;
    logic [p_data_width-1:0]   result_reg;
    logic [p_len_width-1:0]    count_reg;
    logic [p_len_width-1:0]    len_reg;
    logic [1:0]                mode_reg;
    logic                      ready_reg;
    logic                      busy_reg;
    logic                      result_valid_reg;
    logic [p_data_width-1:0]   ident_next;
    logic                      last_elem;
    logic                      lut_we;

    assign ident_next = p_data_width'(acc_identity(i_pe_mode));
    // len is at least 1 whenever this is consulted, so len-1 never wraps.
    assign last_elem  = (count_reg == (len_reg - LEN_ONE));
    assign lut_we     = i_lut_we && (state_reg == ST_IDLE);

    lse_lut_regs u_lut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (lut_we),
        .i_addr  (i_lut_addr),
        .i_wdata (i_lut_wdata),
        .o_table (o_lut_table)
    );

`ifdef LSE_ACC_PIPE_EN
    logic [p_data_width-1:0] b_reg;
    assign o_lse_b = b_reg;
`else
    assign o_lse_b = i_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg        <= ST_IDLE;
            acc_reg          <= p_data_width'(NEG_INF_24);
            result_reg       <= '0;
            count_reg        <= '0;
            len_reg          <= '0;
            mode_reg         <= 2'd0;
            ready_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
`ifdef LSE_ACC_PIPE_EN
            b_reg            <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        len_reg   <= i_len;
                        mode_reg  <= i_pe_mode;
                        acc_reg   <= ident_next;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        if (i_len == '0) begin
                            state_reg        <= ST_DONE;
                            result_reg       <= ident_next;
                            result_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_ACC_ISSUE;
                            ready_reg <= 1'b1;
                        end
                    end
                end
`ifdef LSE_ACC_PIPE_EN
                ST_ACC_ISSUE: begin
                    if (ready_reg && i_data_valid) begin
                        b_reg     <= i_data;
                        ready_reg <= 1'b0;
                        state_reg <= ST_ACC_WB;
                    end
                end
                ST_ACC_WB: begin
                    acc_reg   <= i_lse_sum;
                    count_reg <= count_reg + LEN_ONE;
                    if (last_elem) begin
                        state_reg        <= ST_DONE;
                        result_reg       <= i_lse_sum;
                        result_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_ACC_ISSUE;
                        ready_reg <= 1'b1;
                    end
                end
`else
                ST_ACC_ISSUE: begin
                    if (ready_reg && i_data_valid) begin
                        acc_reg   <= i_lse_sum;
                        count_reg <= count_reg + LEN_ONE;
                        if (last_elem) begin
                            state_reg        <= ST_DONE;
                            ready_reg        <= 1'b0;
                            result_reg       <= i_lse_sum;
                            result_valid_reg <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (i_result_ready) begin
                        state_reg        <= ST_IDLE;
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_data_ready   = ready_reg;
    assign o_lse_a        = acc_reg;
    assign o_lse_mode     = mode_reg;
    assign o_result_valid = result_valid_reg;
    assign o_result       = result_reg;
    assign o_busy         = busy_reg;

endmodule

// File: tb/tb_lse_acc_ctrl.sv
// Randomized bench for lse_acc_ctrl; lse_add is replaced by a behavioural stand-in combiner.
module tb_lse_acc_ctrl;
    import lse_acc_ctrl_pkg::*;

`ifdef LSE_ACC_PIPE_EN
    localparam bit PIPE    = 1'b1;
    localparam int RES_LAT = 2;
`else
    localparam bit PIPE    = 1'b0;
    localparam int RES_LAT = 1;
`endif

    logic                                   i_clk;
    logic                                   i_rst;
    logic                                   i_start;
    logic [15:0]                            i_len;
    logic [1:0]                             i_pe_mode;
    logic                                   i_data_valid;
    logic                                   o_data_ready;
    logic [23:0]                            i_data;
    logic [23:0]                            o_lse_a;
    logic [23:0]                            o_lse_b;
    logic [1:0]                             o_lse_mode;
    logic [23:0]                            i_lse_sum;
    logic                                   i_lut_we;
    logic [LUT_ADDR_W-1:0]                  i_lut_addr;
    logic [LUT_PRECISION-1:0]               i_lut_wdata;
    logic [LUT_SIZE-1:0][LUT_PRECISION-1:0] o_lut_table;
    logic                                   o_result_valid;
    logic                                   i_result_ready;
    logic [23:0]                            o_result;
    logic                                   o_busy;

    int checks   = 0;
    int failures = 0;
    int txn_id   = 0;
    logic [LUT_PRECISION-1:0] lut_model [LUT_SIZE];
    logic [23:0] stim_q [$];

    lse_acc_ctrl #(.p_data_width(24), .p_len_width(16)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_len          (i_len),
        .i_pe_mode      (i_pe_mode),
        .i_data_valid   (i_data_valid),
        .o_data_ready   (o_data_ready),
        .i_data         (i_data),
        .o_lse_a        (o_lse_a),
        .o_lse_b        (o_lse_b),
        .o_lse_mode     (o_lse_mode),
        .i_lse_sum      (i_lse_sum),
        .i_lut_we       (i_lut_we),
        .i_lut_addr     (i_lut_addr),
        .i_lut_wdata    (i_lut_wdata),
        .o_lut_table    (o_lut_table),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_result       (o_result),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [23:0] ref_identity(input logic [1:0] mode);
        return (mode == 2'd0) ? 24'h800000 : 24'h410410;
    endfunction

    // Stand-in combiner: -inf is the identity, otherwise plain wrapping add (per lane when packed).
    function automatic logic [23:0] ref_add(input logic [23:0] a, input logic [23:0] b,
                                            input logic [1:0] mode);
        logic [23:0] r;
        logic [5:0]  al, bl;
        if (mode == 2'd0) begin
            if (a == 24'h800000)      r = b;
            else if (b == 24'h800000) r = a;
            else                      r = a + b;
        end else begin
            r = '0;
            for (int l = 0; l < 4; l++) begin
                al = a[l*6 +: 6];
                bl = b[l*6 +: 6];
                if (al == 6'h10)      r[l*6 +: 6] = bl;
                else if (bl == 6'h10) r[l*6 +: 6] = al;
                else                  r[l*6 +: 6] = al + bl;
            end
        end
        return r;
    endfunction

    always_comb i_lse_sum = ref_add(o_lse_a, o_lse_b, o_lse_mode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_lut();
        for (int i = 0; i < LUT_SIZE; i++)
            check("lut_entry", 32'(o_lut_table[i]), 32'(lut_model[i]));
    endtask

    task automatic lut_write(input int addr, input int data);
        i_lut_we    = 1'b1;
        i_lut_addr  = LUT_ADDR_W'(addr);
        i_lut_wdata = LUT_PRECISION'(data);
        @(posedge i_clk); #1;
        i_lut_we = 1'b0;
        lut_model[addr] = LUT_PRECISION'(data);
    endtask

    // Enters and leaves at 1 time unit after a rising edge with the DUT idle.
    task automatic run_txn(input int len, input logic [1:0] mode, input int vprob,
                           input bit lut_attack, input int abort_after);
        logic [23:0] elems [$];
        logic [23:0] exp_acc;
        int idx, cyc, budget, lat, hold;
        bit prev_hs, hs;
        exp_acc = ref_identity(mode);
        for (int i = 0; i < len; i++) begin
            logic [23:0] e;
            if (stim_q.size() > 0) e = stim_q.pop_front();
            else                   e = 24'($urandom);
            elems.push_back(e);
            exp_acc = ref_add(exp_acc, e, mode);
        end
        txn_id++;
        i_start   = 1'b1;
        i_len     = 16'(len);
        i_pe_mode = mode;
        @(posedge i_clk); #1;
        i_start   = 1'b0;
        i_len     = 16'($urandom);
        i_pe_mode = 2'($urandom);
        idx = 0; cyc = 0; prev_hs = 1'b0; budget = 10 * len + 50;
        while (idx < len && cyc < budget) begin
            i_data_valid = ($urandom_range(0, 99) < vprob);
            i_data       = elems[idx];
            i_start      = ($urandom_range(0, 7) == 0);
            if (lut_attack && cyc == 0) begin
                i_lut_we = 1'b1; i_lut_addr = LUT_ADDR_W'(3); i_lut_wdata = 8'h15;
            end
            @(negedge i_clk);
            check("data_ready", 32'(o_data_ready), (PIPE && prev_hs) ? 32'd0 : 32'd1);
            check("busy_accum", 32'(o_busy), 32'd1);
            check("lse_mode", 32'(o_lse_mode), 32'(mode));
            hs = o_data_ready && i_data_valid;
            if (hs && idx == 0)
                check("lse_a_init", 32'(o_lse_a), 32'(ref_identity(mode)));
            @(posedge i_clk); #1;
            i_lut_we = 1'b0;
            if (hs) idx++;
            prev_hs = hs;
            cyc++;
            if (abort_after >= 0 && idx == abort_after) break;
        end
        i_data_valid = 1'b0;
        i_start      = 1'b0;
        if (abort_after >= 0) begin
            i_rst = 1'b1;
            @(posedge i_clk); #1;
            i_rst = 1'b0;
            @(negedge i_clk);
            check("abort_busy", 32'(o_busy), 32'd0);
            check("abort_valid", 32'(o_result_valid), 32'd0);
            check("abort_ready", 32'(o_data_ready), 32'd0);
            check("abort_lse_a", 32'(o_lse_a), 32'h800000);
            foreach (lut_model[i]) lut_model[i] = '0;
            check_lut();
            repeat (3) begin
                @(negedge i_clk);
                check("abort_no_result", 32'(o_result_valid), 32'd0);
            end
            @(posedge i_clk); #1;
            $display("txn %0d mode=%0d len=%0d aborted after %0d elements", txn_id, mode, len, idx);
            return;
        end
        if (idx < len) check("stream_timeout", 32'(idx), 32'(len));
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
        end while (!o_result_valid && lat < 10);
        check("result_latency", 32'(lat), (len == 0) ? 32'd1 : 32'(RES_LAT));
        hold = (len == 0) ? 5 : $urandom_range(0, 3);
        check("result", 32'(o_result), 32'(exp_acc));
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check("hold_result", 32'(o_result), 32'(exp_acc));
            check("hold_valid", 32'(o_result_valid), 32'd1);
            check("hold_busy", 32'(o_busy), 32'd1);
        end
        i_result_ready = 1'b1;
        i_start        = 1'b1;
        i_len          = 16'd3;
        @(posedge i_clk); #1;
        i_result_ready = 1'b0;
        i_start        = 1'b0;
        @(negedge i_clk);
        check("post_valid", 32'(o_result_valid), 32'd0);
        check("post_busy", 32'(o_busy), 32'd0);
        check("post_ready", 32'(o_data_ready), 32'd0);
        @(posedge i_clk); #1;
        $display("txn %0d mode=%0d len=%0d result=%06h expected=%06h latency=%0d",
                 txn_id, mode, len, o_result, exp_acc, lat);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_pe_mode = '0;
        i_data_valid = 1'b0; i_data = '0; i_lut_we = 1'b0; i_lut_addr = '0;
        i_lut_wdata = '0; i_result_ready = 1'b0;
        foreach (lut_model[i]) lut_model[i] = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_data_ready), 32'd0);
        check("rst_valid", 32'(o_result_valid), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_lse_a", 32'(o_lse_a), 32'h800000);
        check("rst_lse_mode", 32'(o_lse_mode), 32'd0);
        check_lut();
        @(posedge i_clk); #1;

        stim_q.push_back(24'h000400);
        run_txn(1, 2'd0, 100, 1'b0, -1);
        run_txn(0, 2'd0, 100, 1'b0, -1);
        stim_q.push_back(24'h410410);
        stim_q.push_back(24'h000000);
        run_txn(2, 2'd1, 50, 1'b0, -1);

        lut_write(3, 8'h2A);
        @(negedge i_clk);
        check_lut();
        @(posedge i_clk); #1;
        run_txn(8, 2'd0, 80, 1'b1, -1);
        check("lut_locked", 32'(o_lut_table[3]), 32'h2A);

        run_txn(8, 2'd0, 100, 1'b0, 3);
        run_txn(5, 2'd2, 100, 1'b0, -1);
        run_txn(4, 2'd0, 100, 1'b0, -1);

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 1) == 1)
                lut_write($urandom_range(0, LUT_SIZE - 1), $urandom_range(0, 255));
            run_txn($urandom_range(0, 12), 2'($urandom), $urandom_range(30, 100), 1'b0, -1);
        end
        run_txn(200, 2'd3, 90, 1'b0, -1);
        @(negedge i_clk);
        check_lut();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
